// File: rtl/i1_output_arbiter_if.sv
// rtl/i1_output_arbiter_if.sv - flit source, output link and status bundle for i1_output_arbiter
interface i1_output_arbiter_if #(
    parameter int N_PORTS = 4
);
    logic [16*N_PORTS-1:0] in_data;
    logic [N_PORTS-1:0]    in_req;
    logic [N_PORTS-1:0]    in_bussy;
    logic [15:0]           out_data;
    logic                  out_req;
    logic                  out_bussy;
    logic [N_PORTS-1:0]    grant_vec;
    logic                  err;

    // Environment side: flit sources and the downstream link
    modport master (
        output in_data, in_req, out_bussy,
        input  in_bussy, out_data, out_req, grant_vec, err
    );

    // Arbiter side
    modport slave (
        input  in_data, in_req, out_bussy,
        output in_bussy, out_data, out_req, grant_vec, err
    );
endinterface

// File: rtl/i1_output_arbiter.sv
// rtl/i1_output_arbiter.sv - wormhole output arbiter, priority/regular classes, round robin; I1_ARB_STARVE_EN builds the anti-starvation counter
module i1_output_arbiter #(
    parameter int         N_PORTS      = 4,
    parameter int         PW           = 2,
    parameter logic [3:0] STARVE_LIMIT = 4'd15
) (
    input logic               clk,
    input logic               reset,
    i1_output_arbiter_if.slave link
);
    localparam logic [2:0] T_REG  = 3'b000;
    localparam logic [2:0] T_PRI  = 3'b001;
    localparam logic [2:0] T_TAIL = 3'b011;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [PW-1:0]        lock;
    logic [PW-1:0]        rr_ptr;
    logic [15:0]          out_data_r;
    logic                 out_req_r;
    logic [N_PORTS-1:0]   grant_r;
    logic                 err_r;

    logic [N_PORTS-1:0]   reg_head;
    logic [N_PORTS-1:0]   pri_head;
    logic [N_PORTS-1:0]   non_head;
    logic [2:0]           typ;
    logic [N_PORTS-1:0]   cand;
    logic                 pick_reg;
    logic                 force_reg;
    logic [PW-1:0]        win;
    logic                 found;
    int                   idx;
    logic [15:0]          cur_data;
    logic                 cur_req;
    logic                 stall;
    logic                 accept;
    logic [N_PORTS-1:0]   bussy;

    // Sort each presented flit into regular head, priority head or stray non-head
    always_comb begin
        reg_head = '0;
        pri_head = '0;
        non_head = '0;
        typ      = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            typ = link.in_data[16*i+13 +: 3];
            if (link.in_req[i]) begin
                if (typ == T_REG)      reg_head[i] = 1'b1;
                else if (typ == T_PRI) pri_head[i] = 1'b1;
                else                   non_head[i] = 1'b1;
            end
        end
    end

`ifdef I1_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    assign force_reg = (starve_cnt == STARVE_LIMIT) && (|reg_head);

    // Count priority wins taken while a regular head sat waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE && found) begin
            if (pick_reg || !(|reg_head))
                starve_cnt <= 4'd0;
            else if (starve_cnt < STARVE_LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    // Strict priority: the limit only matters when the counter is built
    logic [3:0] unused_starve_limit;
    assign unused_starve_limit = STARVE_LIMIT;
    assign force_reg = 1'b0;
`endif

    assign pick_reg = force_reg || !(|pri_head);
    assign cand     = pick_reg ? reg_head : pri_head;

    // Round-robin search of the chosen class starting at rr_ptr
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (cand[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign cur_data = link.in_data[16*int'(lock) +: 16];
    assign cur_req  = link.in_req[lock];
    assign stall    = out_req_r && link.out_bussy;
    assign accept   = (state == LOCKED) && cur_req && !stall;

    // Heads wait in IDLE, strays are swallowed; only the owner may move when locked
    always_comb begin
        bussy = '1;
        if (reset) begin
            if (state == IDLE) bussy = ~non_head;
            else               bussy[lock] = stall;
        end
    end

    // Lock FSM, round-robin pointer, output register and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            lock       <= '0;
            rr_ptr     <= '0;
            out_data_r <= 16'h0000;
            out_req_r  <= 1'b0;
            grant_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|non_head) err_r <= 1'b1;
                    if (found) begin
                        state   <= LOCKED;
                        lock    <= win;
                        grant_r <= N_PORTS'(1) << win;
                    end
                end
                LOCKED: begin
                    if (accept && cur_data[15:13] == T_TAIL) begin
                        state   <= IDLE;
                        grant_r <= '0;
                        rr_ptr  <= (lock == PW'(N_PORTS - 1)) ? '0 : lock + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                out_data_r <= cur_data;
                out_req_r  <= 1'b1;
            end else if (!link.out_bussy) begin
                out_req_r  <= 1'b0;
            end
        end
    end

    assign link.in_bussy  = bussy;
    assign link.out_data  = out_data_r;
    assign link.out_req   = out_req_r;
    assign link.grant_vec = grant_r;
    assign link.err       = err_r;
endmodule

// File: tb/tb_i1_output_arbiter.sv
// tb/tb_i1_output_arbiter.sv - self-checking bench for i1_output_arbiter
module tb_i1_output_arbiter;
    localparam int         NP   = 4;
    localparam logic [3:0] SLIM = 4'd3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    i1_output_arbiter_if #(.N_PORTS(NP)) link();

    i1_output_arbiter #(.N_PORTS(NP), .PW(2), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk),
        .reset(reset),
        .link(link)
    );

    always #5 clk = ~clk;

    logic [15:0] pf [NP][128];
    bit          st [NP][128];
    int          fl_n [NP];
    int          pk_n [NP];
    int          pk_start [NP][32];
    logic [15:0] exp_q [$];
    int          exp_lock [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        link.in_req = '0;
        link.in_data = '0;
        link.out_bussy = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic [15:0] rand_head(input bit pri);
        return {2'b00, pri, 13'($urandom)};
    endfunction

    task automatic clear_traffic();
        for (int i = 0; i < NP; i++) begin
            fl_n[i] = 0;
            pk_n[i] = 0;
        end
        exp_q.delete();
        exp_lock.delete();
    endtask

    task automatic add_packet(input int p, input logic [15:0] head, input int nbody);
        logic [2:0] t;
        pk_start[p][pk_n[p]] = fl_n[p];
        pk_n[p]++;
        pf[p][fl_n[p]] = head;
        st[p][fl_n[p]] = 1'b1;
        fl_n[p]++;
        for (int b = 0; b < nbody; b++) begin
            t = 3'($urandom_range(7));
            if (t == 3'b011) t = 3'b010;
            pf[p][fl_n[p]] = {t, 13'($urandom)};
            st[p][fl_n[p]] = 1'b0;
            fl_n[p]++;
        end
        pf[p][fl_n[p]] = {3'b011, 13'($urandom)};
        st[p][fl_n[p]] = 1'b0;
        fl_n[p]++;
    endtask

    // Packet-level model: every source with packets left offers its next head at each arbitration
    task automatic build_expected();
        int pidx [NP];
        int rr = 0;
        int cnt = 0;
        bit regw, priw, sel_reg, is_pri;
        int g, i, last;
        for (int p = 0; p < NP; p++) pidx[p] = 0;
        forever begin
            regw = 0;
            priw = 0;
            for (int p = 0; p < NP; p++)
                if (pidx[p] < pk_n[p]) begin
                    if (pf[p][pk_start[p][pidx[p]]][15:13] == 3'b001) priw = 1;
                    else regw = 1;
                end
            if (!regw && !priw) break;
            sel_reg = !priw;
`ifdef I1_ARB_STARVE_EN
            if (cnt == int'(SLIM) && regw) sel_reg = 1;
            if (sel_reg || !regw) cnt = 0;
            else if (cnt < int'(SLIM)) cnt++;
`endif
            g = -1;
            for (int k = 0; k < NP; k++) begin
                i = (rr + k) % NP;
                if (g < 0 && pidx[i] < pk_n[i]) begin
                    is_pri = (pf[i][pk_start[i][pidx[i]]][15:13] == 3'b001);
                    if (is_pri != sel_reg) g = i;
                end
            end
            exp_lock.push_back(g);
            last = (pidx[g] + 1 < pk_n[g]) ? pk_start[g][pidx[g] + 1] : fl_n[g];
            for (int f = pk_start[g][pidx[g]]; f < last; f++) exp_q.push_back(pf[g][f]);
            pidx[g]++;
            rr = (g + 1) % NP;
        end
    endtask

    // bp_mode 0: never busy, 1: random, 2: busy for cycles 6..10
    task automatic run_traffic(input string name, input int bp_mode, input int budget);
        int pos [NP];
        bit acc [NP];
        int oidx = 0;
        int lidx = 0;
        int cyc = 0;
        bit hold = 0;
        logic [15:0] hold_d = '0;
        logic [NP-1:0] prev_g;
        logic [NP-1:0] want;
        build_expected();
        for (int i = 0; i < NP; i++) pos[i] = 0;
        prev_g = link.grant_vec;
        while (oidx < exp_q.size() && cyc < budget) begin
            for (int i = 0; i < NP; i++) begin
                if (pos[i] < fl_n[i] && (st[i][pos[i]] || $urandom_range(3) != 0)) begin
                    link.in_req[i] = 1'b1;
                    link.in_data[16*i +: 16] = pf[i][pos[i]];
                end else begin
                    link.in_req[i] = 1'b0;
                    link.in_data[16*i +: 16] = 16'($urandom);
                end
            end
            case (bp_mode)
                0: link.out_bussy = 1'b0;
                1: link.out_bussy = ($urandom_range(2) == 0);
                default: link.out_bussy = (cyc >= 6 && cyc < 11);
            endcase
            @(negedge clk);
            if (hold) begin
                total++;
                if (link.out_req !== 1'b1 || link.out_data !== hold_d) begin
                    bad++;
                    $display("FAIL %s hold got=%b/%h want=1/%h", name, link.out_req, link.out_data, hold_d);
                end
            end
            if (link.grant_vec != '0 && prev_g == '0) begin
                total++;
                want = '0;
                if (lidx < exp_lock.size()) want[exp_lock[lidx]] = 1'b1;
                if (link.grant_vec !== want) begin
                    bad++;
                    $display("FAIL %s grant_order[%0d] got=%b want=%b", name, lidx, link.grant_vec, want);
                end
                lidx++;
            end
            prev_g = link.grant_vec;
            if (link.out_req && link.out_bussy && link.grant_vec != '0) begin
                total++;
                if ((link.in_bussy & link.grant_vec) !== link.grant_vec) begin
                    bad++;
                    $display("FAIL %s owner_stall in_bussy=%b grant=%b", name, link.in_bussy, link.grant_vec);
                end
            end
            for (int i = 0; i < NP; i++) begin
                acc[i] = link.in_req[i] && !link.in_bussy[i];
                if (acc[i]) begin
                    total++;
                    want = '0;
                    want[i] = 1'b1;
                    if (link.grant_vec !== want) begin
                        bad++;
                        $display("FAIL %s xfer_owner port=%0d grant got=%b want=%b", name, i, link.grant_vec, want);
                    end
                end
            end
            if (link.out_req && !link.out_bussy) begin
                total++;
                if (link.out_data !== exp_q[oidx]) begin
                    bad++;
                    $display("FAIL %s out_data[%0d] got=%h want=%h", name, oidx, link.out_data, exp_q[oidx]);
                end
                oidx++;
            end
            hold = link.out_req && link.out_bussy;
            hold_d = link.out_data;
            step();
            for (int i = 0; i < NP; i++) if (acc[i]) pos[i]++;
            cyc++;
        end
        link.in_req = '0;
        link.out_bussy = 1'b0;
        total++;
        if (oidx < exp_q.size()) begin
            bad++;
            $display("FAIL %s timeout flits got=%0d want=%0d", name, oidx, exp_q.size());
        end
        step();
        step();
        total++;
        if (link.out_req !== 1'b0 || link.grant_vec !== '0 || link.err !== 1'b0 || lidx != exp_lock.size()) begin
            bad++;
            $display("FAIL %s drain out_req=%b grant=%b err=%b locks=%0d want 0/0/0/%0d",
                     name, link.out_req, link.grant_vec, link.err, lidx, exp_lock.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        link.in_req = '1;
        for (int i = 0; i < NP; i++) link.in_data[16*i +: 16] = rand_head(i[0]);
        step();
        total++;
        if (link.in_bussy !== '1 || link.out_req !== 1'b0 || link.out_data !== 16'h0 ||
            link.grant_vec !== '0 || link.err !== 1'b0) begin
            bad++;
            $display("FAIL reset in_bussy=%b out_req=%b out_data=%h grant=%b err=%b want 1111/0/0000/0000/0",
                     link.in_bussy, link.out_req, link.out_data, link.grant_vec, link.err);
        end
        link.in_req = '0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_source();
        do_reset();
        link.in_req = 4'b0100;
        link.in_data[32 +: 16] = 16'h0005;
        #1;
        total++;
        if (link.in_bussy[2] !== 1'b1 || link.grant_vec !== 4'b0000) begin
            bad++;
            $display("FAIL single idle in_bussy2=%b grant=%b want 1/0000", link.in_bussy[2], link.grant_vec);
        end
        step();
        total++;
        if (link.grant_vec !== 4'b0100 || link.in_bussy[2] !== 1'b0 || link.out_req !== 1'b0) begin
            bad++;
            $display("FAIL single grant grant=%b in_bussy2=%b out_req=%b want 0100/0/0", link.grant_vec, link.in_bussy[2], link.out_req);
        end
        step();
        total++;
        if (link.out_req !== 1'b1 || link.out_data !== 16'h0005) begin
            bad++;
            $display("FAIL single head out=%b/%h want 1/0005", link.out_req, link.out_data);
        end
        link.in_data[32 +: 16] = 16'h4001;
        step();
        total++;
        if (link.out_req !== 1'b1 || link.out_data !== 16'h4001) begin
            bad++;
            $display("FAIL single body out=%b/%h want 1/4001", link.out_req, link.out_data);
        end
        link.in_data[32 +: 16] = 16'h6002;
        step();
        link.in_req = '0;
        total++;
        if (link.out_req !== 1'b1 || link.out_data !== 16'h6002 || link.grant_vec !== 4'b0000) begin
            bad++;
            $display("FAIL single tail out=%b/%h grant=%b want 1/6002/0000", link.out_req, link.out_data, link.grant_vec);
        end
        step();
        total++;
        if (link.out_req !== 1'b0) begin
            bad++;
            $display("FAIL single drain out_req got=%b want 0", link.out_req);
        end
    endtask

    task automatic test_class_priority();
        do_reset();
        clear_traffic();
        add_packet(0, 16'h0011, 2);
        add_packet(3, 16'h2011, 2);
        run_traffic("class_priority", 0, 200);
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_traffic();
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < 3; p++) add_packet(p, rand_head(1'b0), 0);
        run_traffic("round_robin", 0, 300);
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_traffic();
        add_packet(1, rand_head(1'b0), 10);
        add_packet(2, rand_head(1'b1), 3);
        run_traffic("backpressure", 2, 300);
    endtask

    task automatic test_starvation();
        do_reset();
        clear_traffic();
        add_packet(0, rand_head(1'b0), 1);
        for (int n = 0; n < 5; n++) add_packet(1, rand_head(1'b1), 0);
        run_traffic("starvation", 0, 400);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_traffic();
            for (int p = 0; p < NP; p++) begin
                int n;
                n = $urandom_range(3);
                for (int k = 0; k < n; k++) add_packet(p, rand_head(1'($urandom_range(1))), $urandom_range(4));
            end
            run_traffic("random", 1, 3000);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        link.in_req = 4'b0001;
        link.in_data[0 +: 16] = 16'h0005;
        step();
        step();
        link.in_req = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        link.in_req = 4'b0001;
        link.in_data[0 +: 16] = 16'h4000;
        #1;
        total++;
        if (link.in_bussy[0] !== 1'b0 || link.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid discard in_bussy0=%b err=%b want 0/0", link.in_bussy[0], link.err);
        end
        step();
        link.in_req = '0;
        total++;
        if (link.err !== 1'b1 || link.out_req !== 1'b0 || link.grant_vec !== '0) begin
            bad++;
            $display("FAIL reset_mid err=%b out_req=%b grant=%b want 1/0/0000", link.err, link.out_req, link.grant_vec);
        end
        step();
        total++;
        if (link.err !== 1'b1 || link.out_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid sticky err=%b out_req=%b want 1/0", link.err, link.out_req);
        end
    endtask

    initial begin
        link.in_req = '0;
        link.in_data = '0;
        link.out_bussy = 1'b0;
        test_reset();
        test_single_source();
        test_class_priority();
        test_round_robin();
        test_backpressure();
        test_starvation();
        test_random();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/i1_output_arbiter.md
# i1_output_arbiter

Wormhole output-port arbiter that shares one 16-bit router output link between `N_PORTS` upstream flit sources, such as per-direction FIFO pairs inside an i1 router. It locks the link to one source from head flit to tail flit. Priority-class packets win over regular-class packets, with round-robin order inside each class and an optional anti-starvation counter. The output is registered and drives the standard `req`/`bussy` link handshake.

## Interface
Parameters:
- `N_PORTS`, 4, number of requesters, legal range 2..8
- `PW`, 2, pointer width, equal to ceil(log2(`N_PORTS`))
- `STARVE_LIMIT`, 4'd15, consecutive priority grants allowed while a regular head waits

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_data`  in  16*`N_PORTS`  flit from source i on bits [16i+15:16i]
- `in_req`  in  `N_PORTS`  source i presents a valid flit
- `in_bussy`  out  `N_PORTS`  0 = the arbiter accepts source i's flit this cycle
- `out_data`  out  16  registered output flit
- `out_req`  out  1  `out_data` is valid
- `out_bussy`  in  1  downstream cannot accept
- `grant_vec`  out  `N_PORTS`  one-hot current lock owner; all zeros when IDLE
- `err`  out  1  sticky protocol error flag

## Operation
Flit type is `data[15:13]`:
- 000 = regular head
- 001 = priority head
- 010 = body
- 011 = tail
- other codes are treated as body
- Heads are multi-flit only: every packet ends with a tail.

Transfer rule:
- An input transfer happens on an edge where `in_req[i]`=1 and `in_bussy[i]`=0.
- An output transfer happens on an edge where `out_req`=1 and `out_bussy`=0.

FSM states are IDLE and LOCKED.

IDLE:
- `in_bussy[i]`=1 for every source presenting a head flit.
- A source presenting a non-head flit gets `in_bussy[i]`=0. That flit is discarded and `err` is set.
- Class select: if `STARVE_LIMIT` is reached and a regular head is waiting, the regular class wins. Otherwise the priority class wins if any priority head is present. Otherwise the regular class wins.
- Winner `g` is the first requesting source of the selected class, searching `rr_ptr`, `rr_ptr`+1, … modulo `N_PORTS`.
- Edge: state goes to LOCKED, the lock register becomes `g`, and `grant_vec` becomes one-hot(`g`).

LOCKED(g):
- `in_bussy[g]` = `out_req & out_bussy`. All other inputs have `in_bussy`=1.
- On each accept: `out_data` <= `in_data[g]` and `out_req` <= 1.
- If there is no accept and `out_bussy`=0, then `out_req` <= 0.
- Accepting a tail: state goes to IDLE, `rr_ptr` <= (g+1) mod `N_PORTS`, and `grant_vec` goes to 0 on the same edge.
- Non-tail flits of type 000 or 001 arriving inside a packet are forwarded unchanged. They do not re-arbitrate.

Output register:
- The output register keeps draining in IDLE.
- It never drops a flit.
- `out_data` holds its value while `out_req`=1 and `out_bussy`=1.

Reset (`reset`=0 at an edge):
- State goes to IDLE, `rr_ptr`=0, `out_req`=0, `out_data`=16'h0000, `grant_vec`=0, `err`=0, `starve_cnt`=0.
- All `in_bussy` outputs are 1 while `reset` is low.
- Reset in the middle of a packet abandons the lock. The remaining body and tail flits of that packet are later discarded in IDLE and set `err`. This is the required behaviour.

## Timing
- Arbitration takes 1 cycle: a head is present in cycle 0 (IDLE), the grant is registered at the end of cycle 0, and the head is accepted at the end of cycle 1 if the output register is free.
- Head-to-`out_req` latency is 2 cycles. Body/tail flits take 1 cycle per flit with no bubbles while `out_bussy`=0.
- After a tail there is one IDLE cycle before the next head can be accepted, so the inter-packet gap is at least 1 cycle.
- A simultaneous output drain and input accept in the same cycle is legal. The register is overwritten with no bubble.
- `err` rises on the edge after a discarded flit and is cleared only by reset.

## Configuration
- `I1_ARB_STARVE_EN` defined: the `starve_cnt` counter (4 bits, saturating at `STARVE_LIMIT`) is built.
  - It increments when a priority head wins while a regular head is waiting.
  - It clears when a regular head wins, or at an arbitration where no regular head is waiting.
  - When it equals `STARVE_LIMIT` and a regular head is waiting, the regular class is forced.
- `I1_ARB_STARVE_EN` undefined: there is no counter and strict priority applies, so regular packets can starve indefinitely.

## Test plan
- Single source: port 2 sends head 16'h0005 (regular), body 16'h4001, tail 16'h6002, with `out_bussy`=0 → `out_req` rises 2 cycles after the head and the three flits appear back-to-back. `grant_vec` goes 4'b0100 → 4'b0000 after the tail.
- Class priority: port 0 presents regular head 16'h0011 and port 3 presents priority head 16'h2011 in the same cycle → port 3's whole packet is forwarded first, then port 0's.
- Round robin: ports 0, 1 and 2 each send repeated 2-flit regular packets → grant order 0, 1, 2, 0, 1 with `rr_ptr` advancing after each tail.
- Backpressure: hold `out_bussy`=1 for 5 cycles in the middle of a packet → `out_data` is stable, `in_bussy[g]`=1, and no flit is lost or duplicated.
- Starvation (`I1_ARB_STARVE_EN` defined, `STARVE_LIMIT`=3): port 1 sends continuous priority packets while port 0 holds a regular head → port 0 is granted after exactly 3 priority packets. With the macro undefined, port 0 is never granted.
- Reset mid-packet: assert `reset`=0 after the head is accepted, then release it and send body 16'h4000 → the flit is discarded and `err`=1 on the next edge. `out_req` stays 0.
